// File: rtl/rtc_bus_controller_pkg.sv
// rtc_bus_controller_pkg: shared state encodings and default phase timings.
//   state_e     : controller states IDLE..DONE
//   T_PULSE_DEF : default strobe phase length in clk cycles
//   T_GAP_DEF   : default inactive-bus gap length in clk cycles
package rtc_bus_controller_pkg;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_GAP1 = 3'd2,
        S_DATA = 3'd3,
        S_GAP2 = 3'd4,
        S_DONE = 3'd5
    } state_e;
    localparam int unsigned T_PULSE_DEF = 4;
    localparam int unsigned T_GAP_DEF   = 2;
endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: down-counter timing one bus phase.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load load_val_i (phase length) on this edge
//   load_val_i  : phase length in cycles, 1..255
//   tc_o        : high during the last cycle of the loaded phase
module rtc_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       tc_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load_i ? load_val_i : (cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q);
    end

    // A phase of N cycles starts with N loaded, so count 1 marks its last cycle.
    assign tc_o = cnt_q == 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/rtc_bus_controller.sv
// rtc_bus_controller: sequences one read or write on a multiplexed RTC bus.
//   clk, rst_n          : clock, async active-low reset
//   start_i             : request a transaction (sampled in IDLE)
//   wr_rd_i             : 1 = write, 0 = read (sampled with start_i)
//   addr_i, wdata_i     : register address and write data (sampled with start_i)
//   ad_in_i             : bus input side
//   ad_out_o, ad_oe_o   : bus output side and its enable
//   cs_n_o, ad_n_o,
//   rd_n_o, wr_n_o      : active-low chip select, address select, read/write strobes
//   busy_o, done_o      : transaction in progress, one-cycle completion pulse
//   rtc_dato_o, hold_o  : last byte read, low for one cycle to let it be captured
module rtc_bus_controller
    import rtc_bus_controller_pkg::*;
#(
    parameter int unsigned T_PULSE = T_PULSE_DEF,
    parameter int unsigned T_GAP   = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       wr_rd_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] ad_in_i,
    output logic [7:0] ad_out_o,
    output logic       ad_oe_o,
    output logic       cs_n_o,
    output logic       ad_n_o,
    output logic       rd_n_o,
    output logic       wr_n_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rtc_dato_o,
    output logic       hold_o
);
    localparam logic [7:0] PULSE = 8'(T_PULSE);
    localparam logic [7:0] GAP   = 8'(T_GAP);

    state_e     state_q, state_d;
    logic       load, tc;
    logic [7:0] load_val;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0] ad_out_q, ad_out_d, rtc_dato_q, rtc_dato_d;
    logic       ad_oe_q, ad_oe_d, cs_n_q, cs_n_d, ad_n_q, ad_n_d;
    logic       rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic       busy_q, busy_d, done_q, done_d, hold_q, hold_d;
    logic       in_addr, in_wdata, in_rdata;

    rtc_phase_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .load_val_i(load_val),
        .tc_o      (tc)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = 8'd0;
        case (state_q)
            S_IDLE: if (start_i) begin state_d = S_ADDR; load = 1'b1; load_val = PULSE; end
            S_ADDR: if (tc)      begin state_d = S_GAP1; load = 1'b1; load_val = GAP;   end
            S_GAP1: if (tc)      begin state_d = S_DATA; load = 1'b1; load_val = PULSE; end
            S_DATA: if (tc)      begin state_d = S_GAP2; load = 1'b1; load_val = GAP;   end
            S_GAP2: if (tc)      state_d = S_DONE;
            default:             state_d = S_IDLE;
        endcase
    end

    // Request fields are captured only when a transaction is accepted.
    assign wr_d    = (state_q == S_IDLE && start_i) ? wr_rd_i : wr_q;
    assign addr_d  = (state_q == S_IDLE && start_i) ? addr_i  : addr_q;
    assign wdata_d = (state_q == S_IDLE && start_i) ? wdata_i : wdata_q;

    // Bus outputs are registered from the current state, so the pins trail
    // the state register by one cycle and never see a path from the inputs.
    assign in_addr  = state_q == S_ADDR;
    assign in_wdata = state_q == S_DATA && wr_q;
    assign in_rdata = state_q == S_DATA && !wr_q;

    always_comb begin
        cs_n_d   = !(in_addr || in_wdata || in_rdata);
        ad_n_d   = !in_addr;
        wr_n_d   = !(in_addr || in_wdata);
        rd_n_d   = !in_rdata;
        ad_oe_d  = in_addr || in_wdata;
        ad_out_d = in_addr ? addr_q : (in_wdata ? wdata_q : 8'h00);
        busy_d   = state_q != S_IDLE;
        done_d   = state_q == S_DONE;
        hold_d   = !(state_q == S_DONE && !wr_q);
        // Sample the bus on the edge that ends the read strobe.
        rtc_dato_d = (!rd_n_q && rd_n_d) ? ad_in_i : rtc_dato_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            ad_out_q   <= 8'h00;
            ad_oe_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            ad_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_q     <= 1'b1;
            rtc_dato_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ad_out_q   <= ad_out_d;
            ad_oe_q    <= ad_oe_d;
            cs_n_q     <= cs_n_d;
            ad_n_q     <= ad_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hold_q     <= hold_d;
            rtc_dato_q <= rtc_dato_d;
        end
    end

    assign ad_out_o   = ad_out_q;
    assign ad_oe_o    = ad_oe_q;
    assign cs_n_o     = cs_n_q;
    assign ad_n_o     = ad_n_q;
    assign rd_n_o     = rd_n_q;
    assign wr_n_o     = wr_n_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign hold_o     = hold_q;
    assign rtc_dato_o = rtc_dato_q;
endmodule

// File: tb/tb_rtc_bus_controller.sv
// tb_rtc_bus_controller: directed checks of the RTC bus controller.
module tb_rtc_bus_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, wr_rd;
    logic [7:0] addr, wdata, ad_in;
    logic [7:0] ad_out, rtc_dato;
    logic       ad_oe, cs_n, ad_n, rd_n, wr_n, busy, done, hold;
    logic       start_f;
    logic [7:0] ad_out_f, rtc_dato_f;
    logic       ad_oe_f, cs_n_f, ad_n_f, rd_n_f, wr_n_f, busy_f, done_f, hold_f;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         clash = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if ((ad_oe && !rd_n) || (ad_oe_f && !rd_n_f)) clash++;

    rtc_bus_controller dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .wr_rd_i(wr_rd),
        .addr_i(addr), .wdata_i(wdata), .ad_in_i(ad_in),
        .ad_out_o(ad_out), .ad_oe_o(ad_oe), .cs_n_o(cs_n), .ad_n_o(ad_n),
        .rd_n_o(rd_n), .wr_n_o(wr_n), .busy_o(busy), .done_o(done),
        .rtc_dato_o(rtc_dato), .hold_o(hold)
    );

    rtc_bus_controller #(.T_PULSE(1), .T_GAP(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .start_i(start_f), .wr_rd_i(1'b0),
        .addr_i(8'h5A), .wdata_i(8'h00), .ad_in_i(8'hA5),
        .ad_out_o(ad_out_f), .ad_oe_o(ad_oe_f), .cs_n_o(cs_n_f), .ad_n_o(ad_n_f),
        .rd_n_o(rd_n_f), .wr_n_o(wr_n_f), .busy_o(busy_f), .done_o(done_f),
        .rtc_dato_o(rtc_dato_f), .hold_o(hold_f)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // {cs_n, ad_n, rd_n, wr_n, ad_oe} expected c cycles after start is sampled (defaults).
    function automatic logic [4:0] strb(input int c, input logic wr);
        if (c >= 1 && c <= 4)  return 5'b00101;
        if (c >= 7 && c <= 10) return wr ? 5'b01101 : 5'b01010;
        return 5'b11110;
    endfunction

    task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] din, input logic [7:0] old, input int poke);
        @(posedge clk); #1;
        wr_rd = wr; addr = a; wdata = d; ad_in = din; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start = (c == poke);
            @(negedge clk);
            chk($sformatf("strobes c=%0d", c), {cs_n, ad_n, rd_n, wr_n, ad_oe}, strb(c, wr));
            chk($sformatf("busy c=%0d", c), busy, c >= 1 && c <= 13);
            chk($sformatf("done c=%0d", c), done, c == 13);
            chk($sformatf("hold c=%0d", c), hold, !(c == 13 && !wr));
            chk($sformatf("rtc_dato c=%0d", c), rtc_dato, (!wr && c >= 11) ? din : old);
            if (c >= 1 && c <= 4) chk($sformatf("ad_out addr c=%0d", c), ad_out, a);
            if (wr && c >= 7 && c <= 10) chk($sformatf("ad_out data c=%0d", c), ad_out, d);
        end
        start = 1'b0;
    endtask

    initial begin
        int ndone;
        int s;
        int q[$];
        rst_n = 1'b0; start = 1'b0; start_f = 1'b0;
        wr_rd = 1'b0; addr = 8'h00; wdata = 8'h00; ad_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset strobes", {cs_n, ad_n, rd_n, wr_n, ad_oe}, 5'b11110);
        chk("reset ad_out", ad_out, 8'h00);
        chk("reset rtc_dato", rtc_dato, 8'h00);
        chk("reset busy/done/hold", {busy, done, hold}, 3'b001);
        chk("reset fast strobes", {cs_n_f, ad_n_f, rd_n_f, wr_n_f, ad_oe_f}, 5'b11110);
        #2 rst_n = 1'b1;

        run_txn(1'b0, 8'h21, 8'h00, 8'h45, 8'h00, -1);
        run_txn(1'b1, 8'h10, 8'h59, 8'hEE, 8'h45, -1);
        run_txn(1'b1, 8'h3C, 8'hC3, 8'h11, 8'h45, 7);

        // Reset during the second read-strobe cycle.
        @(posedge clk); #1;
        wr_rd = 1'b0; addr = 8'h33; ad_in = 8'h99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort rd_n active", rd_n, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort strobes", {cs_n, ad_n, rd_n, wr_n, ad_oe}, 5'b11110);
        chk("abort busy", busy, 1'b0);
        #2 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort done count", ndone, 0);
        chk("abort rtc_dato", rtc_dato, 8'h00);

        // Back-to-back transactions with start held high on the fast instance.
        @(posedge clk); #1;
        s = cyc;
        start_f = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_f) q.push_back(cyc);
        end
        start_f = 1'b0;
        chk("fast done count>=4", q.size() >= 4, 1'b1);
        if (q.size() >= 1) chk("fast latency", q[0] - s, 6);
        for (int i = 0; i < 3; i++)
            if (i + 1 < q.size()) chk($sformatf("fast period %0d", i), q[i+1] - q[i], 6);
        chk("fast rtc_dato", rtc_dato_f, 8'hA5);
        chk("ad_oe/rd_n overlap", clash, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
